// File: rtl/dms_pkg.sv
// rtl/dms_pkg.sv - shared FSM state and vote-decision types for the charge-pump driver
// Contents:
//   dms_state_t  : driver FSM states (ACCUM, PULSE_UP, PULSE_DN)
//   vote_dec_t   : outcome of evaluating one voting window
//   vote_decide  : maps a window's net vote and threshold to a decision
package dms_pkg;

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        PULSE_UP = 2'd1,
        PULSE_DN = 2'd2
    } dms_state_t;

    typedef enum logic [1:0] {
        DEC_QUIET = 2'd0,
        DEC_UP    = 2'd1,
        DEC_DN    = 2'd2
    } vote_dec_t;

    function automatic vote_dec_t vote_decide(input int net, input int thr);
        vote_dec_t dec;
        dec = DEC_QUIET;
        if (net >= thr) begin
            dec = DEC_UP;
        end else if (net <= -thr) begin
            dec = DEC_DN;
        end
        return dec;
    endfunction

endpackage

// File: rtl/dms_cp_vote.sv
// rtl/dms_cp_vote.sv - bang-bang vote accumulator over a window of WIN valid samples
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_en             : accumulation enabled (driver is in ACCUM)
//   i_valid          : phase-detector sample qualifier
//   i_early, i_late  : bang-bang votes (early -> -1, late -> +1, both/neither -> 0)
//   o_done           : this cycle accepts the WIN-th sample of the window
//   o_net_eval       : net vote including this cycle's sample (one bit wider than
//                      the stored net so a full-scale +WIN window is representable)
module dms_cp_vote #(
    parameter int WIN = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic                          i_valid,
    input  logic                          i_early,
    input  logic                          i_late,
    output logic                          o_done,
    output logic signed [$clog2(WIN)+1:0] o_net_eval
);

    localparam int CW = $clog2(WIN);
    localparam int NW = CW + 1;

    logic        [CW-1:0] r_count;
    logic signed [NW-1:0] r_net;
    logic signed [NW:0]   w_step;
    logic                 w_accept;

    assign w_accept = i_en & i_valid;

    always_comb begin
        w_step = '0;
        if (i_late && !i_early) begin
            w_step = (NW+1)'(1);
        end else if (i_early && !i_late) begin
            w_step = '1;
        end
    end

    // Stored net never exceeds +/-(WIN-1) because it is cleared on the WIN-th
    // sample, so only the evaluation value needs the extra bit.
    assign o_net_eval = {r_net[NW-1], r_net} + w_step;
    assign o_done     = w_accept && (r_count == CW'(WIN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_net   <= '0;
        end else if (w_accept) begin
            if (o_done) begin
                r_count <= '0;
                r_net   <= '0;
            end else begin
                r_count <= r_count + CW'(1);
                r_net   <= o_net_eval[NW-1:0];
            end
        end
    end

endmodule

// File: rtl/dms_cp_driver.sv
// rtl/dms_cp_driver.sv - bang-bang CDR charge-pump driver with windowed voting
// Optional feature: define DMS_CP_LOCKDET_EN to enable the quiet-window lock detector;
// otherwise lock is tied to 0.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pd_valid, pd_early, pd_late  : phase-detector sample and votes
//   up, dn                       : charge-pump source/sink enables (mutually exclusive)
//   icp                          : signed pump current (+I_CP / -I_CP / 0.0)
//   busy                         : pulse in progress, samples discarded
//   lock                         : LOCK_CNT consecutive quiet windows seen
module dms_cp_driver
    import dms_pkg::*;
#(
    parameter int  WIN      = 16,
    parameter int  THR      = 2,
    parameter int  PW       = 4,
    parameter real I_CP     = 50e-6,
    parameter int  LOCK_CNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pd_valid,
    input  logic pd_early,
    input  logic pd_late,
    output logic up,
    output logic dn,
    output real  icp,
    output logic busy,
    output logic lock
);

    localparam int PWW = $clog2(PW + 1);

    dms_state_t                    r_state;
    logic                          r_up;
    logic                          r_dn;
    logic [PWW-1:0]                r_pw_cnt;
    logic                          w_done;
    logic signed [$clog2(WIN)+1:0] w_net_eval;
    vote_dec_t                     w_dec;
    logic                          w_eval;

    dms_cp_vote #(.WIN(WIN)) u_vote (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_state == ACCUM),
        .i_valid    (pd_valid),
        .i_early    (pd_early),
        .i_late     (pd_late),
        .o_done     (w_done),
        .o_net_eval (w_net_eval)
    );

    assign w_eval = (r_state == ACCUM) && w_done;
    assign w_dec  = vote_decide(int'(w_net_eval), THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACCUM;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;
            r_pw_cnt <= '0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_eval) begin
                        if (w_dec == DEC_UP) begin
                            r_state  <= PULSE_UP;
                            r_up     <= 1'b1;
                            r_pw_cnt <= PWW'(PW);
                        end else if (w_dec == DEC_DN) begin
                            r_state  <= PULSE_DN;
                            r_dn     <= 1'b1;
                            r_pw_cnt <= PWW'(PW);
                        end
                    end
                end
                PULSE_UP, PULSE_DN: begin
                    // Counter holds the remaining high cycles including the current one;
                    // the last one ends the pulse, so the count never wraps below zero.
                    if (r_pw_cnt <= PWW'(1)) begin
                        r_state  <= ACCUM;
                        r_up     <= 1'b0;
                        r_dn     <= 1'b0;
                        r_pw_cnt <= '0;
                    end else begin
                        r_pw_cnt <= r_pw_cnt - PWW'(1);
                    end
                end
                default: begin
                    r_state <= ACCUM;
                    r_up    <= 1'b0;
                    r_dn    <= 1'b0;
                end
            endcase
        end
    end

    assign up   = r_up;
    assign dn   = r_dn;
    assign busy = r_up | r_dn;

    always_comb begin
        icp = 0.0;
        if (r_up) begin
            icp = I_CP;
        end else if (r_dn) begin
            icp = -I_CP;
        end
    end

`ifdef DMS_CP_LOCKDET_EN
    localparam int LW = $clog2(LOCK_CNT + 1);

    logic [LW-1:0] r_quiet;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quiet <= '0;
        end else if (w_eval) begin
            if (w_dec == DEC_QUIET) begin
                if (r_quiet != LW'(LOCK_CNT)) begin
                    r_quiet <= r_quiet + LW'(1);
                end
            end else begin
                r_quiet <= '0;
            end
        end
    end

    assign lock = (r_quiet == LW'(LOCK_CNT));
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_dms_cp_driver.sv
// tb/tb_dms_cp_driver.sv - directed scoreboard bench for dms_cp_driver (WIN=16, THR=2, PW=4)
module tb_dms_cp_driver;

    localparam int  WIN  = 16;
    localparam int  THR  = 2;
    localparam int  PW   = 4;
    localparam real I_CP = 50e-6;
    localparam int  LCNT = 8;

    logic clk;
    logic rst;
    logic pd_valid;
    logic pd_early;
    logic pd_late;
    logic up;
    logic dn;
    real  icp;
    logic busy;
    logic lock;

    int n_cmp;
    int n_fail;
    int quiet_n;

    logic [2:0] q_exp[$];
    string      q_tag[$];

    dms_cp_driver #(
        .WIN      (WIN),
        .THR      (THR),
        .PW       (PW),
        .I_CP     (I_CP),
        .LOCK_CNT (LCNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pd_valid (pd_valid),
        .pd_early (pd_early),
        .pd_late  (pd_late),
        .up       (up),
        .dn       (dn),
        .icp      (icp),
        .busy     (busy),
        .lock     (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_lock_now();
`ifdef DMS_CP_LOCKDET_EN
        return (quiet_n == LCNT);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        logic [2:0] e;
        string      t;
        real        e_icp;
        logic       e_busy;
        e      = q_exp.pop_front();
        t      = q_tag.pop_front();
        e_icp  = e[2] ? I_CP : (e[1] ? -I_CP : 0.0);
        e_busy = e[2] | e[1];
        n_cmp++;
        assert (up === e[2]) else begin
            n_fail++;
            $error("FAIL %s up: got %b want %b", t, up, e[2]);
        end
        n_cmp++;
        assert (dn === e[1]) else begin
            n_fail++;
            $error("FAIL %s dn: got %b want %b", t, dn, e[1]);
        end
        n_cmp++;
        assert (busy === e_busy) else begin
            n_fail++;
            $error("FAIL %s busy: got %b want %b", t, busy, e_busy);
        end
        n_cmp++;
        assert (lock === e[0]) else begin
            n_fail++;
            $error("FAIL %s lock: got %b want %b", t, lock, e[0]);
        end
        n_cmp++;
        assert (icp == e_icp) else begin
            n_fail++;
            $error("FAIL %s icp: got %g want %g", t, icp, e_icp);
        end
    endtask

    // One clock: drive inputs mid-cycle, queue expectation, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic e, input logic l, input logic r,
                        input logic eu, input logic ed, input string tag);
        @(negedge clk);
        pd_valid = v;
        pd_early = e;
        pd_late  = l;
        rst      = r;
        q_exp.push_back({eu, ed, exp_lock_now()});
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // One 16-sample window: ne early-only, nl late-only, nb both, nn neither (in that order).
    // dir: +1 expect up pulse, -1 dn pulse, 0 quiet. pv drives late-only samples during the pulse.
    // gaps inserts an invalid cycle before every sample.
    task automatic run_window(input string name, input int ne, input int nl, input int nb,
                              input int nn, input int dir, input logic pv, input logic gaps);
        logic e, l, v;
        for (int i = 0; i < WIN; i++) begin
            if (i < ne) begin
                e = 1'b1; l = 1'b0; v = 1'b1;
            end else if (i < ne + nl) begin
                e = 1'b0; l = 1'b1; v = 1'b1;
            end else if (i < ne + nl + nb) begin
                e = 1'b1; l = 1'b1; v = 1'b1;
            end else begin
                e = 1'b0; l = 1'b0; v = 1'b1;
            end
            if (gaps) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("%s gap%0d", name, i));
            end
            if (i == WIN - 1) begin
                if (dir == 0) begin
                    if (quiet_n < LCNT) quiet_n++;
                end else begin
                    quiet_n = 0;
                end
                step(v, e, l, 1'b0, dir > 0, dir < 0, $sformatf("%s eval", name));
            end else begin
                step(v, e, l, 1'b0, 1'b0, 1'b0, $sformatf("%s s%0d", name, i));
            end
        end
        if (dir != 0) begin
            for (int k = 0; k < PW; k++) begin
                step(pv, 1'b0, pv, 1'b0, (dir > 0) && (k < PW - 1), (dir < 0) && (k < PW - 1),
                     $sformatf("%s pulse%0d", name, k));
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        quiet_n  = 0;
        rst      = 1'b1;
        pd_valid = 1'b0;
        pd_early = 1'b0;
        pd_late  = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset0");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset1");

        run_window("late16",   0, 16, 0, 0,  1, 1'b0, 1'b0);
        run_window("e9l7",     9,  7, 0, 0, -1, 1'b0, 1'b0);
        run_window("l9e7",     7,  9, 0, 0,  1, 1'b0, 1'b0);
        run_window("gapped",   0, 16, 0, 0,  1, 1'b0, 1'b1);

        run_window("q_e8l8",   8,  8, 0, 0,  0, 1'b0, 1'b0);
        run_window("q_both",   0,  0, 16, 0, 0, 1'b0, 1'b0);
        run_window("q_plus1",  7,  8, 0, 1,  0, 1'b0, 1'b0);
        run_window("q_minus1", 8,  7, 0, 1,  0, 1'b0, 1'b0);
        run_window("q_none",   0,  0, 0, 16, 0, 1'b0, 1'b0);
        run_window("q_e8l8b",  8,  8, 0, 0,  0, 1'b0, 1'b0);
        run_window("q_both2",  0,  0, 16, 0, 0, 1'b0, 1'b0);
        run_window("q_8th",    8,  8, 0, 0,  0, 1'b0, 1'b0);
        run_window("q_9th",    0,  0, 16, 0, 0, 1'b0, 1'b0);
        run_window("net16",    0, 16, 0, 0,  1, 1'b0, 1'b0);

        run_window("held_a",   0, 16, 0, 0,  1, 1'b1, 1'b0);
        run_window("held_b",   0, 16, 0, 0,  1, 1'b1, 1'b0);

        for (int i = 0; i < WIN - 1; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rstp s%0d", i));
        end
        quiet_n = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rstp eval");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rstp pulse0");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rstp midpulse");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rstp release");
        run_window("after_rst", 0, 16, 0, 0, 1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("partial s%0d", i));
        end
        quiet_n = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "partial rst");
        run_window("fresh", 0, 16, 0, 0, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dms_cp_driver.md
DMS_CP_DRIVER -- requirements
Module: dms_cp_driver

Interface
REQ-001 Parameter WIN, default 16: valid phase-detector samples per voting window (power of two, 4..256).
REQ-002 Parameter THR, default 2: minimum |net vote| per window that triggers a pump pulse.
REQ-003 Parameter PW, default 4: pump pulse width in clk cycles (1..64).
REQ-004 Parameter I_CP, default 50e-6: pump current magnitude in amperes (real).
REQ-005 Parameter LOCK_CNT, default 8: consecutive quiet windows required to declare lock.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 pd_valid  input  1  qualifies early/late for this cycle.
REQ-009 pd_early  input  1  bang-bang vote: data edge early (requests DN).
REQ-010 pd_late  input  1  bang-bang vote: data edge late (requests UP).
REQ-011 up  output  1  charge-pump source enable into the loop-filter node.
REQ-012 dn  output  1  charge-pump sink enable from the loop-filter node.
REQ-013 icp  output  real  signed pump current: +I_CP when up, -I_CP when dn, else 0.0.
REQ-014 busy  output  1  high while a pulse is in progress (samples are discarded).
REQ-015 lock  output  1  loop quiet indication (see Configuration).

Function
REQ-016 FSM states SHALL be ACCUM, PULSE_UP, PULSE_DN; reset state ACCUM.
REQ-017 In ACCUM, each cycle with pd_valid=1 SHALL increment the sample count and add +1 (late only), -1 (early only) or 0 (both or neither) to a signed net vote of width $clog2(WIN)+1.
REQ-018 On the cycle the WIN-th valid sample is accepted, the FSM SHALL evaluate net including that sample and clear count and net for the next cycle.
REQ-019 Evaluation: net >= THR -> PULSE_UP; net <= -THR -> PULSE_DN; otherwise stay ACCUM (quiet window).
REQ-020 up (or dn) SHALL assert on the first cycle after evaluation and remain high exactly PW cycles, then FSM returns to ACCUM.
REQ-021 up and dn SHALL never be high in the same cycle; busy = up | dn.
REQ-022 pd_valid samples during PULSE_UP/PULSE_DN SHALL be discarded and not counted; counting resumes on the first ACCUM cycle.
REQ-023 icp SHALL update in the same cycle as up/dn, with no additional latency.
REQ-024 A pulse width counter of $clog2(PW+1) bits SHALL count down from PW and must not wrap.

Reset
REQ-025 With rst=1 at a rising edge: state=ACCUM, count=0, net=0, up=0, dn=0, busy=0, icp=0.0, lock=0, quiet-window counter=0.
REQ-026 Reset asserted mid-pulse SHALL deassert up/dn at that edge; no residual pulse follows reset release.

Configuration
REQ-027 Macro DMS_CP_LOCKDET_EN defined: a quiet-window counter SHALL increment on each quiet window, saturate at LOCK_CNT, and drive lock=1 when it equals LOCK_CNT; any evaluation that triggers a pulse SHALL clear the counter and lock in the same cycle.
REQ-028 Macro DMS_CP_LOCKDET_EN not defined: the lock port SHALL remain present, tied to 0, with no counter logic.

Structure
REQ-029 The FSM state enum and the vote-to-decision type SHALL reside in package dms_pkg; real/EEnet helpers remain in EE_pkg.
REQ-030 Vote accumulation (count, net, window-done flag) SHALL be sub-module dms_cp_vote; the FSM, pulse timer, icp and lock logic reside in dms_cp_driver.

Verification
REQ-031 WIN=16, THR=2, PW=4: 16 consecutive valid late-only samples -> up high for exactly 4 cycles starting 1 cycle after the 16th sample; icp=+50e-6 during those cycles; dn stays 0.
REQ-032 Window of 9 early-only and 7 late-only samples (net=-2) -> dn pulse of 4 cycles; icp=-50e-6.
REQ-033 Window of 8 early-only and 8 late-only samples, or 16 samples with both flags high -> no pulse; with DMS_CP_LOCKDET_EN, 8 such windows -> lock=1 after the 8th window; a following net=+16 window -> lock=0 coincident with up rising.
REQ-034 pd_valid=1 with late-only held through a pulse -> the 4 in-pulse samples are not counted; the next up pulse begins exactly 16 ACCUM cycles after the prior pulse ends.
REQ-035 rst asserted on the 2nd cycle of an up pulse -> up=0, icp=0.0 at that edge; after release, 16 fresh late-only samples are required before the next pulse.
